// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg
// Shared pipeline definitions for the 64-bit RISC-V five-stage core.
//   - ALUOp class encodings carried from decode to ALU control
//   - id_ex_ctrl_t: the six per-instruction control bits latched in ID/EX
//   - X0: index of the hard-wired zero register
package riscv_pipe_pkg;

   localparam logic [1:0] ALUOP_LDST   = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

   localparam logic [4:0] X0 = 5'd0;

   typedef struct packed {
      logic alu_src;
      logic mem_read;
      logic mem_write;
      logic reg_write;
      logic mem_to_reg;
      logic branch;
   } id_ex_ctrl_t;

   localparam id_ex_ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect
// Combinational load-use hazard detector. Flags the case where the
// instruction in ID reads a register that the load currently in EX has not
// yet produced. Register x0 never hazards, and a resolving taken branch
// masks the hazard since the ID instruction is about to be squashed.
// Ports:
//   id_valid, id_rs1, id_rs2      instruction in decode
//   ex_valid, ex_mem_read, ex_rd  instruction held in ID/EX
//   ex_flush                      taken-branch squash
//   hazard_stall                  hazard this cycle
module load_use_detect
   import riscv_pipe_pkg::*;
(
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   input  logic       ex_flush,
   output logic       hazard_stall
);

   logic src_match;

   assign src_match    = (ex_rd == id_rs1) || (ex_rd == id_rs2);
   assign hazard_stall = id_valid && ex_valid && ex_mem_read &&
                         (ex_rd != X0) && src_match && !ex_flush;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register with load-use bubble insertion, downstream hold
// and taken-branch squash. Update priority per edge: flush, hold, bubble,
// normal load.
// Ports:
//   clk, reset                 clock, async active-high reset
//   id_*                       decoded instruction from ID
//   ex_stall, ex_flush         downstream hold / taken-branch squash
//   id_ex_*                    registered instruction for EX
//   hazard_stall               load-use hazard (combinational)
//   pc_write, if_id_write      front-end enables (combinational)
// Optional build macro HAZARD_STATS_EN adds saturating 32-bit counters
// bubble_count, flush_count and hold_count.
module id_ex_stage
   import riscv_pipe_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_read_data1,
   input  logic [XLEN-1:0] id_read_data2,
   input  logic [XLEN-1:0] id_imm_data,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [3:0]      id_funct,
   input  logic [1:0]      id_alu_op,
   input  logic            id_alu_src,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            id_reg_write,
   input  logic            id_mem_to_reg,
   input  logic            id_branch,
   input  logic            ex_stall,
   input  logic            ex_flush,
   output logic            id_ex_valid,
   output logic [XLEN-1:0] id_ex_pc,
   output logic [XLEN-1:0] id_ex_read_data1,
   output logic [XLEN-1:0] id_ex_read_data2,
   output logic [XLEN-1:0] id_ex_imm_data,
   output logic [4:0]      id_ex_rs1,
   output logic [4:0]      id_ex_rs2,
   output logic [4:0]      id_ex_rd,
   output logic [3:0]      id_ex_funct,
   output logic [1:0]      id_ex_alu_op,
   output logic            id_ex_alu_src,
   output logic            id_ex_mem_read,
   output logic            id_ex_mem_write,
   output logic            id_ex_reg_write,
   output logic            id_ex_mem_to_reg,
   output logic            id_ex_branch,
`ifdef HAZARD_STATS_EN
   output logic [31:0]     bubble_count,
   output logic [31:0]     flush_count,
   output logic [31:0]     hold_count,
`endif
   output logic            hazard_stall,
   output logic            pc_write,
   output logic            if_id_write
);

   id_ex_ctrl_t id_ctrl;
   id_ex_ctrl_t ctrl_q;
   id_ex_ctrl_t ctrl_d;
   logic        valid_d;
   logic        load_en;

   assign id_ctrl = '{alu_src:    id_alu_src,
                      mem_read:   id_mem_read,
                      mem_write:  id_mem_write,
                      reg_write:  id_reg_write,
                      mem_to_reg: id_mem_to_reg,
                      branch:     id_branch};

   load_use_detect u_hazard (
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .ex_valid     (id_ex_valid),
      .ex_mem_read  (ctrl_q.mem_read),
      .ex_rd        (id_ex_rd),
      .ex_flush     (ex_flush),
      .hazard_stall (hazard_stall)
   );

   // A flush overrides any hold: the front end must redirect to the target.
   assign pc_write    = ex_flush || !(hazard_stall || ex_stall);
   assign if_id_write = pc_write;

   // Data fields load on every non-hold edge (bubble and flush included);
   // only valid and control are suppressed, so invalid entries carry
   // don't-care data but never live control.
   assign load_en = ex_flush || !ex_stall;

   always_comb begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
      if (!ex_flush && !hazard_stall && id_valid) begin
         valid_d = 1'b1;
         ctrl_d  = id_ctrl;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_ex_valid      <= 1'b0;
         ctrl_q           <= CTRL_NOP;
         id_ex_pc         <= '0;
         id_ex_read_data1 <= '0;
         id_ex_read_data2 <= '0;
         id_ex_imm_data   <= '0;
         id_ex_rs1        <= '0;
         id_ex_rs2        <= '0;
         id_ex_rd         <= '0;
         id_ex_funct      <= '0;
         id_ex_alu_op     <= '0;
      end else if (load_en) begin
         id_ex_valid      <= valid_d;
         ctrl_q           <= ctrl_d;
         id_ex_pc         <= id_pc;
         id_ex_read_data1 <= id_read_data1;
         id_ex_read_data2 <= id_read_data2;
         id_ex_imm_data   <= id_imm_data;
         id_ex_rs1        <= id_rs1;
         id_ex_rs2        <= id_rs2;
         id_ex_rd         <= id_rd;
         id_ex_funct      <= id_funct;
         id_ex_alu_op     <= id_alu_op;
      end
   end

   assign id_ex_alu_src    = ctrl_q.alu_src;
   assign id_ex_mem_read   = ctrl_q.mem_read;
   assign id_ex_mem_write  = ctrl_q.mem_write;
   assign id_ex_reg_write  = ctrl_q.reg_write;
   assign id_ex_mem_to_reg = ctrl_q.mem_to_reg;
   assign id_ex_branch     = ctrl_q.branch;

`ifdef HAZARD_STATS_EN
   logic bubble_ev;
   logic flush_ev;
   logic hold_ev;

   // Events follow the same priority as the register update.
   assign flush_ev  = ex_flush;
   assign hold_ev   = !ex_flush && ex_stall;
   assign bubble_ev = !ex_flush && !ex_stall && hazard_stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_count <= '0;
         flush_count  <= '0;
         hold_count   <= '0;
      end else begin
         if (bubble_ev && (bubble_count != '1)) bubble_count <= bubble_count + 32'd1;
         if (flush_ev  && (flush_count  != '1)) flush_count  <= flush_count  + 32'd1;
         if (hold_ev   && (hold_count   != '1)) hold_count   <= hold_count   + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Scoreboard bench for id_ex_stage. A driver applies directed and random ID
// traffic, advances a behavioural model of the ID/EX contents, and queues the
// expected visible state; a monitor pops and compares every cycle.
// Build with HAZARD_STATS_EN defined to also check the counters.
module tb_id_ex_stage;

   localparam int XLEN = 64;

   typedef struct packed {
      logic            v;
      logic [XLEN-1:0] pc, rd1, rd2, imm;
      logic [4:0]      rs1, rs2, rd;
      logic [3:0]      funct;
      logic [1:0]      aluop;
      logic            alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch;
   } st_t;

   typedef struct {
      st_t         s;
      logic        haz;
      logic        pcw;
      int unsigned nb, nf, nh;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   st_t  id;
   logic ex_stall, ex_flush;

   logic            o_v, o_alu_src, o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg, o_branch;
   logic [XLEN-1:0] o_pc, o_rd1, o_rd2, o_imm;
   logic [4:0]      o_rs1, o_rs2, o_rd;
   logic [3:0]      o_funct;
   logic [1:0]      o_aluop;
   logic            hazard_stall, pc_write, if_id_write;
`ifdef HAZARD_STATS_EN
   logic [31:0]     bubble_count, flush_count, hold_count;
`endif

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id.v), .id_pc(id.pc), .id_read_data1(id.rd1), .id_read_data2(id.rd2),
      .id_imm_data(id.imm), .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
      .id_funct(id.funct), .id_alu_op(id.aluop), .id_alu_src(id.alu_src),
      .id_mem_read(id.mem_read), .id_mem_write(id.mem_write), .id_reg_write(id.reg_write),
      .id_mem_to_reg(id.mem_to_reg), .id_branch(id.branch),
      .ex_stall(ex_stall), .ex_flush(ex_flush),
      .id_ex_valid(o_v), .id_ex_pc(o_pc), .id_ex_read_data1(o_rd1), .id_ex_read_data2(o_rd2),
      .id_ex_imm_data(o_imm), .id_ex_rs1(o_rs1), .id_ex_rs2(o_rs2), .id_ex_rd(o_rd),
      .id_ex_funct(o_funct), .id_ex_alu_op(o_aluop), .id_ex_alu_src(o_alu_src),
      .id_ex_mem_read(o_mem_read), .id_ex_mem_write(o_mem_write), .id_ex_reg_write(o_reg_write),
      .id_ex_mem_to_reg(o_mem_to_reg), .id_ex_branch(o_branch),
`ifdef HAZARD_STATS_EN
      .bubble_count(bubble_count), .flush_count(flush_count), .hold_count(hold_count),
`endif
      .hazard_stall(hazard_stall), .pc_write(pc_write), .if_id_write(if_id_write)
   );

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          drv_done = 1'b0;

   // Model: what ID/EX should contain, plus event tallies.
   st_t         m;
   int unsigned cb, cf, ch;

   function automatic st_t strip(input st_t s);
      st_t r = s;
      r.v = 1'b0;
      r.alu_src = 0; r.mem_read = 0; r.mem_write = 0;
      r.reg_write = 0; r.mem_to_reg = 0; r.branch = 0;
      return r;
   endfunction

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, exp_v);
      end
   endtask

   // One cycle of stimulus: apply inputs away from the edge, record the
   // expected visible state, then advance the model across the next edge.
   task automatic cyc(input st_t i, input logic stall, input logic flush, input logic rst);
      logic haz;
      exp_t e;
      @(posedge clk); #2;
      reset = rst; id = i; ex_stall = stall; ex_flush = flush;
      if (rst) m = '0;
      haz = i.v && m.v && m.mem_read && (m.rd != 0) &&
            ((m.rd == i.rs1) || (m.rd == i.rs2)) && !flush;
      e.s = m; e.haz = haz; e.pcw = flush || !(haz || stall);
      e.nb = cb; e.nf = cf; e.nh = ch;
      q.push_back(e);
      if (rst) begin
         m = '0; cb = 0; cf = 0; ch = 0;
      end else if (flush) begin
         m = strip(i); cf++;
      end else if (stall) begin
         ch++;
      end else if (haz) begin
         m = strip(i); cb++;
      end else begin
         m = i.v ? i : strip(i);
      end
   endtask

   function automatic st_t rnd_instr();
      st_t r;
      r.v = ($urandom_range(0, 7) != 0);
      r.pc = {$urandom, $urandom}; r.rd1 = {$urandom, $urandom};
      r.rd2 = {$urandom, $urandom}; r.imm = {$urandom, $urandom};
      r.rs1 = 5'($urandom_range(0, 3)); r.rs2 = 5'($urandom_range(0, 3));
      r.rd = 5'($urandom_range(0, 3));
      r.funct = 4'($urandom); r.aluop = 2'($urandom_range(0, 2));
      r.mem_read = $urandom_range(0, 1); r.mem_write = $urandom_range(0, 1);
      r.alu_src = $urandom_range(0, 1); r.reg_write = $urandom_range(0, 1);
      r.mem_to_reg = $urandom_range(0, 1); r.branch = $urandom_range(0, 1);
      return r;
   endfunction

   function automatic st_t ld(input logic [4:0] rd);
      st_t r = '0;
      r.v = 1; r.pc = 64'h1000; r.rd1 = 64'h2000; r.imm = 64'h8; r.rs1 = 5'd2;
      r.rd = rd; r.funct = 4'b0011; r.aluop = 2'b00;
      r.alu_src = 1; r.mem_read = 1; r.reg_write = 1; r.mem_to_reg = 1;
      return r;
   endfunction

   function automatic st_t add(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
      st_t r = '0;
      r.v = 1; r.pc = 64'h1004; r.rd1 = 64'h11; r.rd2 = 64'h22;
      r.rs1 = a; r.rs2 = b; r.rd = rd; r.aluop = 2'b10; r.reg_write = 1;
      return r;
   endfunction

   // Monitor: compare DUT outputs against the oldest queued expectation.
   initial begin
      exp_t e;
      st_t  act;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            act = '{o_v, o_pc, o_rd1, o_rd2, o_imm, o_rs1, o_rs2, o_rd, o_funct, o_aluop,
                    o_alu_src, o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg, o_branch};
            check("id_ex_state", 512'(act), 512'(e.s));
            check("hazard_stall", 512'(hazard_stall), 512'(e.haz));
            check("pc_write", 512'(pc_write), 512'(e.pcw));
            check("if_id_write", 512'(if_id_write), 512'(e.pcw));
`ifdef HAZARD_STATS_EN
            check("bubble_count", 512'(bubble_count), 512'(e.nb));
            check("flush_count", 512'(flush_count), 512'(e.nf));
            check("hold_count", 512'(hold_count), 512'(e.nh));
`endif
         end
      end
   end

   initial begin
      st_t nop, a;
      int  budget;
      nop = '0; m = '0; cb = 0; cf = 0; ch = 0;
      reset = 1'b1; id = '0; ex_stall = 0; ex_flush = 0;
      cyc(nop, 0, 0, 1);
      cyc(nop, 0, 0, 1);
      // ld x5 ; add x6,x5,x7 -> one bubble, add held in IF/ID then captured
      cyc(ld(5'd5), 0, 0, 0);
      cyc(add(5'd6, 5'd5, 5'd7), 0, 0, 0);
      cyc(add(5'd6, 5'd5, 5'd7), 0, 0, 0);
      cyc(nop, 0, 0, 0);
      // ld x0 ; add x6,x0,x7 -> no hazard
      cyc(ld(5'd0), 0, 0, 0);
      cyc(add(5'd6, 5'd0, 5'd7), 0, 0, 0);
      cyc(nop, 0, 0, 0);
      // three-cycle hold while ID changes
      cyc(add(5'd9, 5'd1, 5'd2), 0, 0, 0);
      for (int k = 0; k < 3; k++) cyc(rnd_instr(), 1, 0, 0);
      cyc(nop, 0, 0, 0);
      // second load-use pair
      cyc(ld(5'd3), 0, 0, 0);
      cyc(add(5'd4, 5'd1, 5'd3), 0, 0, 0);
      cyc(add(5'd4, 5'd1, 5'd3), 0, 0, 0);
      // hazard, hold and flush together -> flush wins
      cyc(ld(5'd8), 0, 0, 0);
      cyc(add(5'd6, 5'd8, 5'd7), 1, 1, 0);
      cyc(nop, 0, 0, 0);
      // hazard under hold: hold wins, hazard persists until released
      cyc(ld(5'd10), 0, 0, 0);
      cyc(add(5'd6, 5'd10, 5'd7), 1, 0, 0);
      cyc(add(5'd6, 5'd10, 5'd7), 0, 0, 0);
      cyc(add(5'd6, 5'd10, 5'd7), 0, 0, 0);
      // reset mid-bubble with a live writer in ID
      cyc(ld(5'd5), 0, 0, 0);
      a = add(5'd6, 5'd5, 5'd7);
      cyc(a, 0, 0, 0);
      cyc(a, 0, 0, 1);
      cyc(a, 0, 0, 0);
      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         a = rnd_instr();
         cyc(a, ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 99) == 0));
      end
      cyc(nop, 0, 0, 0);
      drv_done = 1'b1;
      budget = 0;
      while (q.size() > 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      if (q.size() > 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain: %0d entries left, want 0", q.size());
      end
      @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
